// File: rtl/boot_rdbk_pkg.sv
// Shared constants, register map and FSM encoding for the boot SRAM readback checker.
package boot_rdbk_pkg;

  localparam int unsigned DATA_W      = 32;
  localparam int unsigned ADDR_W      = 32;
  localparam int unsigned SRAM_ADDR_W = 15;
  localparam int unsigned STRB_W      = DATA_W / 8;
  localparam int unsigned WIDX_W      = SRAM_ADDR_W - 2;
  // One extra bit so a full-SRAM word count is representable.
  localparam int unsigned CNT_W       = SRAM_ADDR_W - 1;
  localparam int unsigned WORDS       = 1 << WIDX_W;

  localparam logic [1:0] RDBK_CTRL = 2'd0;
  localparam logic [1:0] RDBK_LEN  = 2'd1;
  localparam logic [1:0] RDBK_EXP  = 2'd2;
  localparam logic [1:0] RDBK_SUM  = 2'd3;

  localparam int unsigned CTRL_START = 0;
  localparam int unsigned CTRL_BUSY  = 0;
  localparam int unsigned CTRL_DONE  = 1;
  localparam int unsigned CTRL_PASS  = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_DONE = 2'd2
  } rdbk_state_e;

  // CTRL read-back layout, LSB first: busy, done, pass.
  typedef struct packed {
    logic [DATA_W-4:0] rsvd;
    logic              is_pass;
    logic              is_done;
    logic              is_busy;
  } ctrl_status_t;

  // Word counts beyond the SRAM size saturate to the full SRAM.
  function automatic logic [CNT_W-1:0] clamp_len(input logic [DATA_W-1:0] w);
    return (w > DATA_W'(WORDS)) ? CNT_W'(WORDS) : CNT_W'(w);
  endfunction

endpackage

// File: rtl/boot_rdbk.sv
// Boot readback checker: sums the SRAM image word by word and compares the
// 32-bit additive checksum against a CPU-programmed expected value.
module boot_rdbk
  import boot_rdbk_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_valid,
  input  logic [1:0]        cpu_address,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic [STRB_W-1:0] cpu_wstrb,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ready,
  output logic              sram_valid,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [STRB_W-1:0] sram_wstrb,
  input  logic [DATA_W-1:0] sram_rdata,
  input  logic              sram_ready,
  output logic              done,
  output logic              pass
);

  rdbk_state_e       state_q;
  logic              start_q;
  logic              cpu_ready_q;
  logic [DATA_W-1:0] cpu_rdata_q;
  logic [CNT_W-1:0]  len_q;
  logic [DATA_W-1:0] exp_q;
  logic [DATA_W-1:0] sum_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              sram_valid_q;
  logic [ADDR_W-1:0] sram_addr_q;
  logic              done_q;
  logic              pass_q;

  logic              wr_c;
  logic              busy_c;
  logic              start_c;
  logic              len_we_c;
  logic              exp_we_c;
  ctrl_status_t      status_c;
  logic [DATA_W-1:0] rd_mux_c;
  logic [CNT_W-1:0]  cnt_inc_c;
  logic [ADDR_W-1:0] next_addr_c;

  // Register decode; a pending start counts as busy so the run's LEN/EXPECTED are frozen.
  always_comb begin
    wr_c        = cpu_valid && (cpu_wstrb != '0);
    busy_c      = (state_q != ST_IDLE) || start_q;
    start_c     = wr_c && !busy_c && (cpu_address == RDBK_CTRL) && cpu_wdata[CTRL_START];
    len_we_c    = wr_c && !busy_c && (cpu_address == RDBK_LEN);
    exp_we_c    = wr_c && !busy_c && (cpu_address == RDBK_EXP);
    status_c         = '0;
    status_c.is_busy = busy_c;
    status_c.is_done = done_q;
    status_c.is_pass = pass_q;
    rd_mux_c    = '0;
    case (cpu_address)
      RDBK_CTRL: rd_mux_c = status_c;
      RDBK_LEN:  rd_mux_c = DATA_W'(len_q);
      RDBK_EXP:  rd_mux_c = exp_q;
      default:   rd_mux_c = sum_q;
    endcase
    cnt_inc_c   = cnt_q + CNT_W'(1);
    next_addr_c = ADDR_W'({cnt_inc_c[WIDX_W-1:0], 2'b00});
  end

  // CPU slave: one-cycle acknowledge, registered read data and config registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cpu_ready_q <= 1'b0;
      cpu_rdata_q <= '0;
      start_q     <= 1'b0;
      len_q       <= '0;
      exp_q       <= '0;
    end else begin
      cpu_ready_q <= cpu_valid;
      cpu_rdata_q <= cpu_valid ? rd_mux_c : '0;
      start_q     <= start_c;
      if (len_we_c) len_q <= clamp_len(cpu_wdata);
      if (exp_we_c) exp_q <= cpu_wdata;
    end
  end

  // Readback FSM: one outstanding SRAM read, accumulate on each acknowledge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      sum_q        <= '0;
      cnt_q        <= '0;
      sram_valid_q <= 1'b0;
      sram_addr_q  <= '0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_q) begin
            sum_q       <= '0;
            cnt_q       <= '0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            sram_addr_q <= '0;
            if (len_q == '0) begin
              state_q <= ST_DONE;
            end else begin
              state_q      <= ST_READ;
              sram_valid_q <= 1'b1;
            end
          end
        end
        ST_READ: begin
          if (sram_ready) begin
            sum_q <= sum_q + sram_rdata;
            cnt_q <= cnt_inc_c;
            if (cnt_inc_c == len_q) begin
              sram_valid_q <= 1'b0;
              state_q      <= ST_DONE;
            end else begin
              sram_addr_q <= next_addr_c;
            end
          end
        end
        ST_DONE: begin
          pass_q  <= (sum_q == exp_q);
          done_q  <= 1'b1;
          state_q <= ST_IDLE;
        end
        default: begin
          sram_valid_q <= 1'b0;
          state_q      <= ST_IDLE;
        end
      endcase
    end
  end

  assign cpu_ready  = cpu_ready_q;
  assign cpu_rdata  = cpu_rdata_q;
  assign sram_valid = sram_valid_q;
  assign sram_addr  = sram_addr_q;
  assign sram_wstrb = '0;
  assign done       = done_q;
  assign pass       = pass_q;

endmodule

// File: doc/boot_rdbk.md
Name: boot_rdbk

Overview:
- Boot readback checker: reads back the SRAM image after the boot loader has copied it, and accumulates a 32-bit additive checksum.
- Compares the checksum against a CPU-programmed expected value and reports pass/fail.
- Is the reader counterpart of the boot SRAM write master: a master on the SRAM read port and a slave on the CPU native register interface.
- Uses the same byte addressing (word index << 2).

Parameters:
- DATA_W, 32, data width of the CPU and SRAM buses.
- ADDR_W, 32, width of the SRAM byte address.
- SRAM_ADDR_W, 15, SRAM byte-address bits; number of words is 2**(SRAM_ADDR_W-2).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- cpu_valid  in  1  CPU register access request
- cpu_address  in  2  register select (word index)
- cpu_wdata  in  DATA_W  write data
- cpu_wstrb  in  DATA_W/8  write strobes; nonzero = write, zero = read
- cpu_rdata  out  DATA_W  registered read data
- cpu_ready  out  1  access acknowledge
- sram_valid  out  1  SRAM read request
- sram_addr  out  ADDR_W  SRAM byte address (word index << 2)
- sram_wstrb  out  DATA_W/8  constant zero (read only)
- sram_rdata  in  DATA_W  SRAM read data, valid when sram_ready=1
- sram_ready  in  1  SRAM acknowledge
- done  out  1  check finished (level)
- pass  out  1  checksum matched (valid when done=1)

Behaviour:
- Reset values: cpu_rdata=0, cpu_ready=0, sram_valid=0, sram_addr=0, done=0, pass=0; LEN=0, EXPECTED=0, SUM=0; FSM in IDLE.
- CPU register map:
  - 0 CTRL. Write: bit0=start. Read: bit0=busy, bit1=done, bit2=pass.
  - 1 LEN: word count. Stored clamped to 2**(SRAM_ADDR_W-2).
  - 2 EXPECTED: expected checksum.
  - 3 SUM: read only; writes ignored.
- CPU handshake:
  - cpu_ready is asserted the cycle after cpu_valid, for one cycle per cycle of cpu_valid (cpu_ready <= cpu_valid).
  - cpu_rdata is registered alongside cpu_ready.
  - The strobe is treated as all-or-nothing: any nonzero cpu_wstrb writes the full word.
- Writes to LEN or EXPECTED while busy are ignored. A start while busy is ignored.
- FSM states IDLE, READ, DONE:
  - IDLE: on start, clear SUM, word counter=0, done=0, pass=0.
    - If LEN==0, go directly to DONE.
    - Otherwise go to READ with sram_valid=1 and sram_addr=0 on the next cycle.
  - READ: hold sram_valid, sram_addr stable until sram_ready=1.
    - On sram_ready: SUM <= SUM + sram_rdata (mod 2**32) and increment the counter.
    - If counter+1 == LEN: deassert sram_valid, go to DONE.
    - Else present the next address the following cycle. sram_valid may stay high back-to-back; the address updates on the ready cycle.
    - Exactly one outstanding request at a time. sram_rdata is sampled only when sram_ready=1.
  - DONE: for one cycle evaluate pass <= (SUM == EXPECTED), then set done=1 and return to IDLE.
    - done and pass hold until the next start.
    - pass is computed with the SUM that includes the last word.
- Wrap-around: the word counter width is SRAM_ADDR_W-1, so LEN = full SRAM size does not overflow. The address never exceeds (2**(SRAM_ADDR_W-2)-1) << 2.
- Simultaneous events:
  - A start write on the same cycle the FSM enters IDLE from DONE is accepted.
  - A CPU read of SUM during READ returns the partial sum.
- Reset mid-operation: everything returns asynchronously to reset values. sram_valid drops immediately; any in-flight sram_ready is ignored.
- An sram_ready arriving in IDLE or DONE is ignored.
- Latency: LEN=N with zero-wait SRAM completes with done=1 exactly N+2 cycles after the start write is accepted.

Decomposition:
- Shared header boot_rdbk.vh:
  - register index constants RDBK_CTRL=0, RDBK_LEN=1, RDBK_EXP=2, RDBK_SUM=3;
  - CTRL bit positions;
  - FSM state encodings (2 bits).
- Uses global DATA_W/ADDR_W from the system header.
- No sub-module: the accumulator and counter are small enough to stay inline.

Test Plan:
- Reset: assert rst mid-READ (LEN=16) -> sram_valid=0 asynchronously; CTRL reads 0; SUM reads 0.
- Match: SRAM preloaded with words 1..8, LEN=8, EXPECTED=36, start, zero-wait ready -> SUM=36, done=1, pass=1; done rises 10 cycles after start.
- Mismatch with wait states: same image, EXPECTED=37, ready delayed 3 cycles per request -> addresses 0x0..0x1C issued in order, each held stable until ready; pass=0.
- Boundary LEN=0: EXPECTED=0 -> done=1, pass=1, no sram_valid; EXPECTED=5 -> pass=0.
- Wrap and clamp:
  - LEN written as 0xFFFFFFFF -> reads back 8192.
  - Full sweep with all words 0xFFFFFFFF -> last address 0x7FFC; SUM = 0xFFFFE000 (mod 2**32).
- Busy protection: during READ, write LEN=1, EXPECTED=0, and start -> all ignored; original run completes unchanged; cpu_ready pulses for each access.
